// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and masked compare helper for serial pattern detectors
package seq_det_pkg;
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL = 1'b1;
  localparam int MAX_W = 64;
  function automatic logic masked_eq(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b, input logic [MAX_W-1:0] m);
    return ((a ^ b) & m) == '0;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that saturates at all ones, clear has priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= clr ? '0 : (inc && q != '1) ? q + W'(1) : q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time configurable N-bit serial pattern detector with registered match pulse
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pat,
  input  logic [N-1:0]     cfg_mask,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int FW = $clog2(N + 1);
  logic [N-1:0] hist, pat, msk, nh;
  logic [FW-1:0] fill;
  logic smp, match;
  assign smp = en && !cfg_we;
  assign nh = {hist[N-2:0], x};
  // fill counts bits held in hist that may still take part in a match
  assign match = smp && fill >= FW'(N - 1) && masked_eq(MAX_W'(nh), MAX_W'(pat), MAX_W'(msk));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      fill <= '0;
      pat <= PATTERN;
      msk <= '1;
      y <= 1'b0;
    end else begin
      y <= match;
      if (cfg_we) begin
        pat <= cfg_pat;
        msk <= cfg_mask;
        fill <= '0;
      end else if (en) begin
        hist <= nh;
        fill <= (match && overlap == MODE_NONOVL) ? '0 : (fill == FW'(N)) ? fill : fill + FW'(1);
      end
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(match),
    .q(match_cnt)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  logic clk = 0, rst = 1, en = 0, x = 0, overlap = 0, cfg_we = 0, cnt_clr = 0;
  logic [3:0] cfg_pat = 4'b0, cfg_mask = 4'b0;
  logic y;
  logic [1:0] match_cnt;
  int compared = 0, mismatched = 0;

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .cfg_we(cfg_we),
    .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_y(input logic ey, input string tag);
    compared++;
    assert (y === ey) else begin
      mismatched++;
      $error("FAIL %s: y observed %b expected %b", tag, y, ey);
    end
  endtask

  task automatic chk_cnt(input logic [1:0] ec, input string tag);
    compared++;
    assert (match_cnt === ec) else begin
      mismatched++;
      $error("FAIL %s: match_cnt observed %0d expected %0d", tag, match_cnt, ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic ey, input string tag);
    en = 1; x = b;
    tick();
    chk_y(ey, tag);
  endtask

  task automatic stall(input string tag);
    en = 0; x = 1;
    tick();
    chk_y(1'b0, tag);
  endtask

  task automatic cfg(input logic [3:0] p, input logic [3:0] m, input string tag);
    cfg_we = 1; cfg_pat = p; cfg_mask = m; cnt_clr = 1; en = 1; x = 1;
    tick();
    chk_y(1'b0, tag);
    chk_cnt(2'd0, {tag, "_cnt"});
    cfg_we = 0; cnt_clr = 0;
  endtask

  initial begin
    #12;
    chk_y(1'b0, "reset_y");
    chk_cnt(2'd0, "reset_cnt");
    rst = 0;
    @(negedge clk);

    overlap = 0;
    bit_in(1, 0, "nov_b1"); bit_in(0, 0, "nov_b2"); bit_in(1, 0, "nov_b3"); bit_in(1, 1, "nov_b4");
    bit_in(0, 0, "nov_b5"); bit_in(1, 0, "nov_b6"); bit_in(1, 0, "nov_b7");
    chk_cnt(2'd1, "nov_cnt");

    cfg(4'b1011, 4'b1111, "cfg_ovl");
    overlap = 1;
    bit_in(1, 0, "ovl_b1"); bit_in(0, 0, "ovl_b2"); bit_in(1, 0, "ovl_b3"); bit_in(1, 1, "ovl_b4");
    bit_in(0, 0, "ovl_b5"); bit_in(1, 0, "ovl_b6"); bit_in(1, 1, "ovl_b7");
    chk_cnt(2'd2, "ovl_cnt");

    cfg(4'b1011, 4'b1101, "cfg_mask");
    overlap = 0;
    bit_in(1, 0, "msk_b1"); bit_in(0, 0, "msk_b2"); bit_in(0, 0, "msk_b3"); bit_in(1, 1, "msk_b4");
    bit_in(1, 0, "msk_c1"); bit_in(1, 0, "msk_c2"); bit_in(0, 0, "msk_c3"); bit_in(1, 0, "msk_c4");
    chk_cnt(2'd1, "msk_cnt");

    cfg(4'b1011, 4'b1111, "cfg_rst");
    bit_in(1, 0, "rst_p1"); bit_in(0, 0, "rst_p2"); bit_in(1, 0, "rst_p3");
    en = 0;
    rst = 1; #2;
    chk_y(1'b0, "rst_async_y");
    rst = 0;
    @(negedge clk);
    bit_in(1, 0, "rst_f1"); bit_in(0, 0, "rst_f2"); bit_in(1, 0, "rst_f3"); bit_in(1, 1, "rst_f4");

    cfg(4'b1111, 4'b1111, "cfg_sat");
    overlap = 1;
    bit_in(1, 0, "sat_1"); bit_in(1, 0, "sat_2"); bit_in(1, 0, "sat_3"); bit_in(1, 1, "sat_4");
    bit_in(1, 1, "sat_5"); bit_in(1, 1, "sat_6"); bit_in(1, 1, "sat_7"); bit_in(1, 1, "sat_8");
    chk_cnt(2'd3, "sat_cnt");
    cnt_clr = 1;
    bit_in(1, 1, "clr_y");
    chk_cnt(2'd0, "clr_cnt");
    cnt_clr = 0;
    bit_in(1, 1, "post_clr_y");
    chk_cnt(2'd1, "post_clr_cnt");

    cfg(4'b1011, 4'b1111, "cfg_en");
    overlap = 0;
    bit_in(1, 0, "en_b1"); stall("en_s1"); bit_in(0, 0, "en_b2"); stall("en_s2");
    bit_in(1, 0, "en_b3"); bit_in(1, 1, "en_b4");
    chk_cnt(2'd1, "en_cnt");
    bit_in(1, 0, "mid_b1"); bit_in(0, 0, "mid_b2"); bit_in(1, 0, "mid_b3");
    cfg_we = 1; cfg_pat = 4'b1011; cfg_mask = 4'b1111; en = 1; x = 1;
    tick();
    chk_y(1'b0, "mid_cfg_y");
    cfg_we = 0;
    bit_in(1, 0, "mid_f1"); bit_in(0, 0, "mid_f2"); bit_in(1, 0, "mid_f3"); bit_in(1, 1, "mid_f4");
    chk_cnt(2'd2, "mid_cnt");

    cfg(4'b0110, 4'b0000, "cfg_zero");
    overlap = 1;
    bit_in(0, 0, "z_1"); bit_in(1, 0, "z_2"); bit_in(0, 0, "z_3"); bit_in(1, 1, "z_4"); bit_in(0, 1, "z_5");
    overlap = 0;
    bit_in(1, 1, "z_6"); bit_in(1, 0, "z_7"); bit_in(0, 0, "z_8"); bit_in(0, 0, "z_9"); bit_in(1, 1, "z_10");
    en = 0;
    tick();
    chk_y(1'b0, "idle_y");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
